// File: rtl/cfg_write_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cfg_write_arbiter
//
// Shares the single write port of the SNN parameter memory between the SPI
// slave (configuration writes, buffered in a small FIFO) and the SNN core's
// parameter-update requester. Arbitration is round-robin between the two
// sources, and the core can freeze all new grants with mem_lock while a
// timestep is being evaluated.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   spi_we/addr/data        SPI write strobe (level, one request per rising
//                           edge) with address/data valid at that edge
//   core_req/addr/data      core write request, held with stable addr/data
//                           until core_gnt
//   mem_lock                high = issue no new grants
//   core_gnt                one-cycle pulse coincident with a core mem_we
//   mem_we/addr/data        parameter memory write port; addr/data hold
//                           their last value while mem_we is low
//   fifo_level, fifo_full   SPI FIFO occupancy and full flag
//   overflow                sticky: an SPI write was dropped
// -----------------------------------------------------------------------------
module cfg_write_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_we,
    input  logic [ADDR_W-1:0]             spi_addr,
    input  logic [DATA_W-1:0]             spi_data,
    input  logic                          core_req,
    input  logic [ADDR_W-1:0]             core_addr,
    input  logic [DATA_W-1:0]             core_data,
    input  logic                          mem_lock,
    output logic                          core_gnt,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPI_WR  = 2'd1,
        CORE_WR = 2'd2
    } state_t;

    typedef enum logic {
        WIN_SPI  = 1'b0,
        WIN_CORE = 1'b1
    } winner_t;

    state_t  state;
    state_t  next_state;
    winner_t last_winner;

    logic                 spi_we_prev;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_empty;
    logic                 spi_pending;
    logic                 core_pending;

    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic [ENTRY_W-1:0]   fifo_head;

    // -------------------------------------------------------------------------
    // SPI strobe edge detect and FIFO control
    // -------------------------------------------------------------------------
    assign push_req   = spi_we & ~spi_we_prev;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_LEVEL);
    assign fifo_level = count;
    assign fifo_head  = fifo_mem[rd_ptr];

    // A pop only ever happens when entering SPI_WR, which itself requires a
    // non-empty FIFO, so a push into a full FIFO is safe whenever pop is high.
    assign pop     = (next_state == SPI_WR);
    assign push_ok = push_req & (~fifo_full | pop);

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours; = here would create
    // order-dependent simulation and mismatch the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Reset to 1 so a strobe held high through reset release is not
            // mistaken for a fresh rising edge.
            spi_we_prev <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            spi_we_prev <= spi_we;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind the pointers, which are reset, so clearing it would add a reset
    // net to every bit for no functional benefit.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {spi_addr, spi_data};
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM
    // -------------------------------------------------------------------------
    assign spi_pending  = ~fifo_empty;
    // The core's own grant cycle does not count as a pending request: the
    // core drops core_req on seeing core_gnt, so it must not be re-granted.
    assign core_pending = core_req & (state != CORE_WR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= WIN_CORE;
        end else begin
            state <= next_state;
            if (next_state == SPI_WR) begin
                last_winner <= WIN_SPI;
            end else if (next_state == CORE_WR) begin
                last_winner <= WIN_CORE;
            end
        end
    end

    // NOTE: next_state gets a default before any branch so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = IDLE;
        if (mem_lock) begin
            next_state = IDLE;
        end else if (spi_pending && core_pending) begin
            next_state = (last_winner == WIN_CORE) ? SPI_WR : CORE_WR;
        end else if (spi_pending) begin
            next_state = SPI_WR;
        end else if (core_pending) begin
            next_state = CORE_WR;
        end
    end

    assign mem_we   = (state == SPI_WR) || (state == CORE_WR);
    assign core_gnt = (state == CORE_WR);

    // Write address/data are registered on entry to a write state and simply
    // hold afterwards, so the port stays stable while mem_we is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_data <= '0;
        end else if (next_state == SPI_WR) begin
            {mem_addr, mem_data} <= fifo_head;
        end else if (next_state == CORE_WR) begin
            mem_addr <= core_addr;
            mem_data <= core_data;
        end
    end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cfg_write_arbiter
//
// Directed stimulus pushes the expected memory writes (address, data, and
// whether it is a core write) into a scoreboard queue in the order the
// arbiter must issue them; an independent monitor pops and compares every
// mem_we cycle. Status outputs and latencies are checked inline.
// -----------------------------------------------------------------------------
module tb_cfg_write_arbiter;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              is_core;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        spi_we;
    logic [ADDR_W-1:0]           spi_addr;
    logic [DATA_W-1:0]           spi_data;
    logic                        core_req;
    logic [ADDR_W-1:0]           core_addr;
    logic [DATA_W-1:0]           core_data;
    logic                        mem_lock;
    logic                        core_gnt;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        fifo_full;
    logic                        overflow;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   we_count     = 0;
    int   last_we_cyc  = -1;
    exp_t exp_q[$];
    int   wr_log[$];
    exp_t mon_e;

    cfg_write_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_we    (spi_we),
        .spi_addr  (spi_addr),
        .spi_data  (spi_data),
        .core_req  (core_req),
        .core_addr (core_addr),
        .core_data (core_data),
        .mem_lock  (mem_lock),
        .core_gnt  (core_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .fifo_level(fifo_level),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: every write cycle is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                we_count++;
                last_we_cyc = cyc;
                wr_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_write", {31'd0, mem_we}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(mem_data), 32'(mon_e.data));
                    check("wr_gnt",  {31'd0, core_gnt}, {31'd0, mon_e.is_core});
                end
            end else if (core_gnt) begin
                check("gnt_without_we", {31'd0, mem_we}, 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic is_core);
        exp_t e;
        e.addr    = a;
        e.data    = d;
        e.is_core = is_core;
        exp_q.push_back(e);
    endtask

    // One SPI request: strobe high for a cycle, then low for a cycle.
    task automatic spi_strobe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        spi_addr = a;
        spi_data = d;
        spi_we   = 1'b1;
        step();
        spi_we   = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_core_gnt(output int gnt_cyc);
        gnt_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (core_gnt) begin
                gnt_cyc = cyc;
                break;
            end
        end
        check("core_gnt_seen", {31'd0, core_gnt}, 32'd1);
        core_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_we); i++) begin
            step();
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_burst(input int n);
        check("burst_len", 32'(wr_log.size()), 32'(n));
        for (int i = 1; i < wr_log.size(); i++) begin
            check("back_to_back", 32'(wr_log[i] - wr_log[i-1]), 32'd1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_we"},     {31'd0, mem_we},    32'd0);
        check({tag, "_core_gnt"},   {31'd0, core_gnt},  32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),      32'd0);
        check({tag, "_mem_data"},   32'(mem_data),      32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level),    32'd0);
        check({tag, "_fifo_full"},  {31'd0, fifo_full}, 32'd0);
        check({tag, "_overflow"},   {31'd0, overflow},  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gnt_cyc;
        int we_before;

        reset     = 1'b1;
        spi_we    = 1'b0;
        spi_addr  = '0;
        spi_data  = '0;
        core_req  = 1'b0;
        core_addr = '0;
        core_data = '0;
        mem_lock  = 1'b0;

        // Reset state, during and after reset.
        step();
        check_idle_outputs("rst");
        step();
        reset = 1'b0;
        step();
        check_idle_outputs("post_rst");

        // Single SPI write: two-cycle latency, exactly one pulse.
        we_before = we_count;
        expect_wr(4'h3, 8'hA5, 1'b0);
        n = cyc;
        spi_strobe(4'h3, 8'hA5);
        repeat (5) step();
        check("spi_single_count",   32'(we_count - we_before), 32'd1);
        check("spi_single_latency", 32'(last_we_cyc - n),      32'd2);
        check("spi_single_level",   32'(fifo_level),           32'd0);

        // Single core write: one-cycle latency, held address/data afterwards.
        expect_wr(4'h5, 8'h3C, 1'b1);
        core_addr = 4'h5;
        core_data = 8'h3C;
        core_req  = 1'b1;
        n = cyc;
        wait_core_gnt(gnt_cyc);
        check("core_latency", 32'(gnt_cyc - n), 32'd1);
        repeat (3) step();
        check("hold_addr", 32'(mem_addr), 32'h5);
        check("hold_data", 32'(mem_data), 32'h3C);

        // Contention from reset: SPI wins first, then core, then SPI.
        do_reset();
        mem_lock = 1'b1;
        spi_strobe(4'h1, 8'h21);
        spi_strobe(4'h2, 8'h22);
        core_addr = 4'h9;
        core_data = 8'h11;
        core_req  = 1'b1;
        step();
        check("contend_level", 32'(fifo_level), 32'd2);
        expect_wr(4'h1, 8'h21, 1'b0);
        expect_wr(4'h9, 8'h11, 1'b1);
        expect_wr(4'h2, 8'h22, 1'b0);
        wr_log.delete();
        mem_lock = 1'b0;
        wait_core_gnt(gnt_cyc);
        wait_drain();
        check_burst(3);

        // Lock: 20 cycles with 3 strobes, no writes, then 3 back-to-back.
        we_before = we_count;
        mem_lock  = 1'b1;
        spi_strobe(4'hA, 8'h01);
        spi_strobe(4'hB, 8'h02);
        spi_strobe(4'hC, 8'h03);
        repeat (14) step();
        check("lock_no_write", 32'(we_count - we_before), 32'd0);
        check("lock_level",    32'(fifo_level),           32'd3);
        expect_wr(4'hA, 8'h01, 1'b0);
        expect_wr(4'hB, 8'h02, 1'b0);
        expect_wr(4'hC, 8'h03, 1'b0);
        wr_log.delete();
        mem_lock = 1'b0;
        wait_drain();
        check_burst(3);

        // Overflow: fifth strobe while locked and full is dropped.
        mem_lock = 1'b1;
        spi_strobe(4'h4, 8'h40);
        spi_strobe(4'h5, 8'h50);
        spi_strobe(4'h6, 8'h60);
        spi_strobe(4'h7, 8'h70);
        check("ovf_full_after4", {31'd0, fifo_full}, 32'd1);
        check("ovf_clear_after4", {31'd0, overflow}, 32'd0);
        spi_strobe(4'h8, 8'h80);
        check("ovf_set_after5", {31'd0, overflow}, 32'd1);
        check("ovf_level",      32'(fifo_level),   32'd4);
        expect_wr(4'h4, 8'h40, 1'b0);
        expect_wr(4'h5, 8'h50, 1'b0);
        expect_wr(4'h6, 8'h60, 1'b0);
        expect_wr(4'h7, 8'h70, 1'b0);
        wr_log.delete();
        mem_lock = 1'b0;
        wait_drain();
        repeat (3) step();
        check_burst(4);
        check("ovf_sticky",      {31'd0, overflow},  32'd1);
        check("ovf_full_drained", {31'd0, fifo_full}, 32'd0);

        // Reset mid-operation, with the SPI strobe held across release.
        do_reset();
        mem_lock = 1'b1;
        spi_strobe(4'hD, 8'hD0);
        spi_strobe(4'hE, 8'hE0);
        core_addr = 4'h2;
        core_data = 8'h77;
        core_req  = 1'b1;
        check("midrst_level", 32'(fifo_level), 32'd2);
        spi_we = 1'b1;
        reset  = 1'b1;
        exp_q.delete();
        #1;
        check_idle_outputs("midrst");
        step();
        core_req = 1'b0;
        mem_lock = 1'b0;
        step();
        we_before = we_count;
        reset = 1'b0;
        repeat (6) step();
        check("midrst_no_write", 32'(we_count - we_before), 32'd0);
        check("midrst_level_after", 32'(fifo_level), 32'd0);
        spi_we = 1'b0;
        step();

        // Full FIFO, push in the same cycle as the first pop: accepted.
        mem_lock = 1'b1;
        spi_strobe(4'h1, 8'hF1);
        spi_strobe(4'h2, 8'hF2);
        spi_strobe(4'h3, 8'hF3);
        spi_strobe(4'h4, 8'hF4);
        check("fullpop_full", {31'd0, fifo_full}, 32'd1);
        expect_wr(4'h1, 8'hF1, 1'b0);
        expect_wr(4'h2, 8'hF2, 1'b0);
        expect_wr(4'h3, 8'hF3, 1'b0);
        expect_wr(4'h4, 8'hF4, 1'b0);
        expect_wr(4'h5, 8'hF5, 1'b0);
        wr_log.delete();
        spi_addr = 4'h5;
        spi_data = 8'hF5;
        spi_we   = 1'b1;
        mem_lock = 1'b0;
        step();
        spi_we = 1'b0;
        check("fullpop_level",    32'(fifo_level),   32'd4);
        check("fullpop_overflow", {31'd0, overflow}, 32'd0);
        wait_drain();
        check_burst(5);
        check("fullpop_ovf_end", {31'd0, overflow}, 32'd0);
        check("fullpop_level_end", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
